// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus bundle for the two-port SRAM arbiter.
// slave: arbiter side; master: requesters plus the SRAM macro.
interface sram_arbiter_if #(parameter int AW = 16);
    logic          p0_valid, p1_valid;
    logic [31:0]   p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic [3:0]    p0_wstrb, p1_wstrb;
    logic          p0_ready, p1_ready;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          p0_err, p1_err;
    logic [AW-1:0] sram_address;
    logic [3:0]    sram_byteena;
    logic [31:0]   sram_data;
    logic          sram_wren;
    logic [31:0]   sram_q;

    modport slave (
        input  p0_valid, p1_valid, p0_addr, p1_addr, p0_wdata, p1_wdata,
               p0_wstrb, p1_wstrb, sram_q,
        output p0_ready, p1_ready, p0_rdata, p1_rdata, p0_err, p1_err,
               sram_address, sram_byteena, sram_data, sram_wren
    );

    modport master (
        output p0_valid, p1_valid, p0_addr, p1_addr, p0_wdata, p1_wdata,
               p0_wstrb, p1_wstrb, sram_q,
        input  p0_ready, p1_ready, p0_rdata, p1_rdata, p0_err, p1_err,
               sram_address, sram_byteena, sram_data, sram_wren
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// One access every three cycles: IDLE (grant) -> ACC (SRAM samples) -> RESP
// (read data arrives); the ready pulse is registered out of RESP.
module sram_arbiter #(
    parameter int AW = 16
) (
    input logic           clock,
    input logic           reset,
    sram_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        last;      // port granted most recently
    logic        gnt;       // port owning the transaction in flight
    logic        gnt_oor;   // in-flight access is out of range
    logic        gnt_wr;    // in-flight access is a write

    logic        sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        sel_oor;

    // Pick the requester to grant: alternate on contention, else whoever asks.
    always_comb begin
        sel = 1'b0;
        if (bus.p0_valid && bus.p1_valid)
            sel = ~last;
        else if (bus.p1_valid)
            sel = 1'b1;
        sel_addr  = sel ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
        sel_wstrb = sel ? bus.p1_wstrb : bus.p0_wstrb;
        sel_oor   = (sel_addr >> (AW + 2)) != 32'd0;
    end

    // FSM plus registered SRAM command; write strobes live only in ACC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last             <= 1'b1;
            gnt              <= 1'b0;
            gnt_oor          <= 1'b0;
            gnt_wr           <= 1'b0;
            bus.sram_address <= '0;
            bus.sram_byteena <= 4'b0000;
            bus.sram_data    <= 32'd0;
            bus.sram_wren    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.p0_valid || bus.p1_valid) begin
                        state            <= ACC;
                        gnt              <= sel;
                        last             <= sel;
                        gnt_oor          <= sel_oor;
                        gnt_wr           <= |sel_wstrb;
                        bus.sram_address <= sel_addr[AW+1:2];
                        bus.sram_data    <= sel_wdata;
                        // An out-of-range access must never touch the array.
                        bus.sram_byteena <= sel_oor ? 4'b0000 : sel_wstrb;
                        bus.sram_wren    <= !sel_oor && (|sel_wstrb);
                    end
                end
                ACC: begin
                    state            <= RESP;
                    bus.sram_byteena <= 4'b0000;
                    bus.sram_wren    <= 1'b0;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response pulse: sram_q is valid during RESP and is captured on leaving it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.p0_ready <= 1'b0;
            bus.p1_ready <= 1'b0;
            bus.p0_rdata <= 32'd0;
            bus.p1_rdata <= 32'd0;
            bus.p0_err   <= 1'b0;
            bus.p1_err   <= 1'b0;
        end else begin
            bus.p0_ready <= 1'b0;
            bus.p1_ready <= 1'b0;
            bus.p0_rdata <= 32'd0;
            bus.p1_rdata <= 32'd0;
            bus.p0_err   <= 1'b0;
            bus.p1_err   <= 1'b0;
            if (state == RESP) begin
                if (gnt) begin
                    bus.p1_ready <= 1'b1;
                    bus.p1_err   <= gnt_oor;
                    bus.p1_rdata <= (gnt_oor || gnt_wr) ? 32'd0 : bus.sram_q;
                end else begin
                    bus.p0_ready <= 1'b1;
                    bus.p0_err   <= gnt_oor;
                    bus.p0_rdata <= (gnt_oor || gnt_wr) ? 32'd0 : bus.sram_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM behavioural macro, a transaction-level
// memory model checked on every ready pulse, and directed scenarios with
// literal expectations for latency, arbitration order and data.
module tb_sram_arbiter;
    localparam int AW = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_arbiter_if #(.AW(AW)) bus();
    sram_arbiter #(.AW(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wren_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (bus.sram_wren) wren_cnt <= wren_cnt + 1;

    // SRAM macro: registered read, byte-masked write.
    logic [31:0] smem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (bus.sram_wren)
            for (int b = 0; b < 4; b++)
                if (bus.sram_byteena[b])
                    smem[bus.sram_address][b*8 +: 8] <= bus.sram_data[b*8 +: 8];
        bus.sram_q <= smem[bus.sram_address];
    end

    // Reference memory, updated in completion order.
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic        act     [0:1];
    logic [31:0] r_addr  [0:1];
    logic [31:0] r_wdata [0:1];
    logic [3:0]  r_wstrb [0:1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Every cycle: exclusivity, quiet outputs when idle, model data on ready.
    always @(negedge clock) begin
        logic        rdy, err, oor, wr;
        logic [31:0] rdata, exp;
        logic [AW-1:0] w;
        if (!reset) begin
            check("ready exclusive", 32'(bus.p0_ready && bus.p1_ready), 32'd0);
            for (int n = 0; n < 2; n++) begin
                rdy   = n ? bus.p1_ready : bus.p0_ready;
                err   = n ? bus.p1_err   : bus.p0_err;
                rdata = n ? bus.p1_rdata : bus.p0_rdata;
                if (rdy) begin
                    if (!act[n]) begin
                        check("unexpected ready", 32'd1, 32'd0);
                    end else begin
                        oor = (r_addr[n] >> (AW + 2)) != 32'd0;
                        wr  = r_wstrb[n] != 4'b0000;
                        w   = r_addr[n][AW+1:2];
                        exp = (oor || wr) ? 32'd0 : ref_mem[w];
                        check("model rdata", rdata, exp);
                        check("model err", 32'(err), 32'(oor));
                        if (wr && !oor)
                            for (int b = 0; b < 4; b++)
                                if (r_wstrb[n][b]) ref_mem[w][b*8 +: 8] = r_wdata[n][b*8 +: 8];
                    end
                end else begin
                    check("idle rdata", rdata, 32'd0);
                    check("idle err", 32'(err), 32'd0);
                end
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        act[p] = v; r_addr[p] = a; r_wdata[p] = wd; r_wstrb[p] = ws;
        if (p == 0) begin
            bus.p0_valid = v; bus.p0_addr = a; bus.p0_wdata = wd; bus.p0_wstrb = ws;
        end else begin
            bus.p1_valid = v; bus.p1_addr = a; bus.p1_wdata = wd; bus.p1_wstrb = ws;
        end
    endtask

    // One transaction; lat = cycles from valid to ready, -1 on timeout.
    task automatic req(input int p, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd,
                       output logic er, output int lat);
        int c0;
        @(negedge clock); #1;
        drive(p, 1'b1, a, wd, ws);
        c0 = cyc; lat = -1; rd = 32'hx; er = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #1;
            if (p == 0 ? bus.p0_ready : bus.p1_ready) begin
                lat = cyc - c0;
                rd  = p == 0 ? bus.p0_rdata : bus.p1_rdata;
                er  = p == 0 ? bus.p0_err   : bus.p1_err;
                break;
            end
        end
        drive(p, 1'b0, 32'd0, 32'd0, 4'b0000);
    endtask

    task automatic pulse_reset();
        @(negedge clock); #1 reset = 1'b1;
        @(negedge clock); #1 reset = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst p0_ready", 32'(bus.p0_ready), 32'd0);
        check("rst p1_ready", 32'(bus.p1_ready), 32'd0);
        check("rst p0_rdata", bus.p0_rdata, 32'd0);
        check("rst p1_rdata", bus.p1_rdata, 32'd0);
        check("rst err", 32'(bus.p0_err | bus.p1_err), 32'd0);
        check("rst sram_address", 32'(bus.sram_address), 32'd0);
        check("rst sram_byteena", 32'(bus.sram_byteena), 32'd0);
        check("rst sram_data", bus.sram_data, 32'd0);
        check("rst sram_wren", 32'(bus.sram_wren), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd1;
        logic        er, er1;
        int          lat, lat1, w0;

        for (int i = 0; i < (1<<AW); i++) begin smem[i] = 32'd0; ref_mem[i] = 32'd0; end
        drive(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        drive(1, 1'b0, 32'd0, 32'd0, 4'b0000);

        // Reset state
        repeat (2) @(negedge clock);
        check_reset_outputs();
        #1 reset = 1'b0;

        // Write then read back through port 0
        req(0, 32'h100, 32'hA5A5_1234, 4'b1111, rd, er, lat);
        check("wr latency", 32'(lat), 32'd3);
        check("wr err", 32'(er), 32'd0);
        check("wr rdata", rd, 32'd0);
        req(0, 32'h100, 32'd0, 4'b0000, rd, er, lat);
        check("rd latency", 32'(lat), 32'd3);
        check("rd data", rd, 32'hA5A5_1234);
        check("rd err", 32'(er), 32'd0);

        // Byte lane merge
        req(0, 32'h200, 32'h1122_3344, 4'b1111, rd, er, lat);
        req(0, 32'h200, 32'h0000_CC00, 4'b0010, rd, er, lat);
        req(0, 32'h200, 32'd0, 4'b0000, rd, er, lat);
        check("byte merge", rd, 32'h1122_CC44);

        // Out-of-range write aliases word 0 but must not land
        req(0, 32'h0, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
        w0 = wren_cnt;
        req(1, 32'h0004_0000, 32'h5555_5555, 4'b1111, rd, er, lat);
        check("oor latency", 32'(lat), 32'd3);
        check("oor err", 32'(er), 32'd1);
        check("oor rdata", rd, 32'd0);
        check("oor wren pulses", 32'(wren_cnt - w0), 32'd0);
        req(0, 32'h0, 32'd0, 4'b0000, rd, er, lat);
        check("oor word0 intact", rd, 32'hDEAD_BEEF);

        // Same cycle: p1 write, p0 read of same word; p1 wins since p0 went last
        fork
            req(1, 32'h300, 32'hCAFE_F00D, 4'b1111, rd1, er1, lat1);
            req(0, 32'h300, 32'd0, 4'b0000, rd, er, lat);
        join
        check("b2b p1 latency", 32'(lat1), 32'd3);
        check("b2b p0 latency", 32'(lat), 32'd6);
        check("b2b read new data", rd, 32'hCAFE_F00D);

        // Reset while a write sits in ACC
        @(negedge clock); #1;
        drive(0, 1'b1, 32'h400, 32'h1234_5678, 4'b1111);
        @(negedge clock); #1;
        check("acc wren before reset", 32'(bus.sram_wren), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async wren drop", 32'(bus.sram_wren), 32'd0);
        check("async byteena drop", 32'(bus.sram_byteena), 32'd0);
        drive(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clock);
        check_reset_outputs();
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            check("no ready after abort", 32'({bus.p1_ready, bus.p0_ready}), 32'd0);
        end
        req(0, 32'h400, 32'd0, 4'b0000, rd, er, lat);
        check("idle after reset latency", 32'(lat), 32'd3);
        check("aborted write absent", rd, 32'd0);

        // Continuous contention from a fresh reset: p0 first, then alternate
        pulse_reset();
        @(negedge clock); #1;
        drive(0, 1'b1, 32'h100, 32'd0, 4'b0000);
        drive(1, 1'b1, 32'h200, 32'd0, 4'b0000);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock); #1;
            check("rr p0_ready", 32'(bus.p0_ready), 32'(i == 3 || i == 9));
            check("rr p1_ready", 32'(bus.p1_ready), 32'(i == 6 || i == 12));
        end
        drive(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        drive(1, 1'b0, 32'd0, 32'd0, 4'b0000);
        repeat (4) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 16, meaning SRAM word-address width (memory = 2^AW 32-bit words).
REQ-002 The block SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-004 The block SHALL have ports pN_valid (N=0,1), input, 1, meaning requester N has a transaction pending.
REQ-005 The block SHALL have ports pN_addr, input, 32, meaning byte address; bits [1:0] are ignored.
REQ-006 The block SHALL have ports pN_wdata, input, 32, meaning write data.
REQ-007 The block SHALL have ports pN_wstrb, input, 4, meaning byte write enables; 0000 means read.
REQ-008 The block SHALL have ports pN_ready, output, 1, meaning a one-cycle transaction-complete pulse.
REQ-009 The block SHALL have ports pN_rdata, output, 32, meaning read data, valid while pN_ready=1.
REQ-010 The block SHALL have ports pN_err, output, 1, meaning out-of-range access, valid while pN_ready=1.
REQ-011 The block SHALL have port sram_address, output, AW, meaning SRAM word address.
REQ-012 The block SHALL have port sram_byteena, output, 4, meaning SRAM byte enables.
REQ-013 The block SHALL have port sram_data, output, 32, meaning SRAM write data.
REQ-014 The block SHALL have port sram_wren, output, 1, meaning SRAM write enable.
REQ-015 The block SHALL have port sram_q, input, 32, meaning SRAM read data, valid one cycle after the address is sampled.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACC and RESP.
REQ-017 In IDLE, when any pN_valid=1, the FSM SHALL register the grant, address, data, byteena and wren onto the sram_* outputs and move to ACC.
REQ-018 The SRAM word address SHALL be pN_addr[AW+1:2].
REQ-019 sram_wren SHALL be 1 in ACC only, and only for a granted in-range write.
REQ-020 ACC SHALL always move to RESP after one cycle.
REQ-021 In RESP, the FSM SHALL pulse pG_ready=1 for the granted port G only, drive pG_rdata=sram_q for reads, and return to IDLE.
REQ-022 Latency SHALL be: valid sampled at edge k, then ready high in the cycle after edge k+2; one access per 3 cycles.
REQ-023 Arbitration SHALL be round-robin: if both ports are valid in IDLE, grant the port not granted last; a single valid requester is always granted.
REQ-024 The last-grant pointer SHALL reset to 1, so port 0 wins the first contention.
REQ-025 An access with pN_addr[31:AW+2] nonzero SHALL be out of range: no SRAM write, pG_err=1 in RESP, pG_rdata=0.
REQ-026 pN_rdata SHALL be 0 whenever pN_ready=0.
REQ-027 pN_err SHALL be 0 whenever pN_ready=0.
REQ-028 For a write, pG_rdata SHALL be 0.
REQ-029 Requesters SHALL hold valid, addr, wdata and wstrb stable until ready; the arbiter samples them only in IDLE.
REQ-030 A requester that keeps valid high after ready SHALL be treated as a new request in the next IDLE cycle, subject to round-robin.
REQ-031 A requester that drops valid before ready SHALL not abort the transaction in flight; the ready pulse is still issued.
REQ-032 Outside ACC, sram_wren SHALL be 0 and sram_byteena SHALL be 0000.
REQ-033 A read issued immediately after a write to the same word SHALL return the written data; no bypass logic is required because of the SRAM write timing.

Reset
REQ-034 While reset=1, the FSM SHALL enter IDLE immediately, asynchronously.
REQ-035 While reset=1, all pN_ready, pN_rdata and pN_err outputs SHALL be 0.
REQ-036 While reset=1, sram_address, sram_byteena and sram_data SHALL be 0, and sram_wren SHALL be 0.
REQ-037 While reset=1, the last-grant pointer SHALL be set to 1.
REQ-038 Reset asserted in ACC SHALL deassert sram_wren in the same cycle; the interrupted transaction SHALL produce no ready pulse.
REQ-039 After reset deasserts, the first valid request SHALL be sampled at the first rising edge.

Verification
REQ-040 The bench SHALL cover: p0 write addr 0x100, wdata 0xA5A5_1234, wstrb 1111, then p0 read 0x100 -> p0_ready 3 cycles after each valid, p0_rdata=0xA5A5_1234, p0_err=0.
REQ-041 The bench SHALL cover: p0 and p1 both continuously valid -> grants alternate 0,1,0,1; each port gets ready every 6 cycles; p1_ready never coincides with p0_ready.
REQ-042 The bench SHALL cover: byte write wstrb 0010, wdata 0x0000_CC00 to a word holding 0x1122_3344 -> readback 0x1122_CC44.
REQ-043 The bench SHALL cover: p1 write to addr 0x0004_0000 with AW=16 -> p1_err=1, p1_rdata=0, sram_wren never 1, and a subsequent read of word 0 is unchanged.
REQ-044 The bench SHALL cover: reset pulsed in ACC of a write -> sram_wren drops asynchronously, no ready pulse, and the FSM is in IDLE after reset.
REQ-045 The bench SHALL cover: back-to-back write then read of the same word from different ports -> the read returns the new data.
